clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
- Run-time programmable integer clock divider: produces registered divided clock clk_o and a one-cycle period-start strobe tick_o from clk_i.
- Divisor loaded through a valid/ready handshake; changes take effect only at a period boundary, so clk_o never glitches or shows a runt pulse.
- Enable start/stop is glitch-free. Feeds peripheral clock enables (UART, SPI, display refresh) and replaces the fixed divide-by-2.

Parameters:
- WIDTH, 8, width of divisor and internal counter.
- RESET_DIV, 2, divisor active after reset; must satisfy 2 <= RESET_DIV <= 2^WIDTH-1.

Ports:
- clk_i  in  1  input clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  run request (level).
- cfg_valid_i  in  1  new divisor offered.
- cfg_div_i  in  WIDTH  requested divisor D.
- cfg_ready_o  out  1  divisor can be accepted this cycle.
- clk_o  out  1  divided clock, registered.
- tick_o  out  1  one-cycle pulse in the first clk_i cycle of each clk_o period.
- div_o  out  WIDTH  divisor currently in effect.
- running_o  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync-style release): state=IDLE, cnt=0, clk_o=0, tick_o=0, running_o=0, div_o=RESET_DIV, no pending update, cfg_ready_o=1.
- Clamp: any accepted cfg_div_i of 0 or 1 is stored as 2. Max divisor is 2^WIDTH-1.
- H = ceil(D/2), the high time. D even gives 50% duty; D odd gives high (D+1)/2 cycles and low (D-1)/2 cycles.
- State IDLE:
  - clk_o=0, tick_o=0, cnt=0.
  - A handshake (cfg_valid_i & cfg_ready_o) writes div_o directly at that edge.
  - en_i=1 at an edge: go to RUN. At the same edge cnt=0, clk_o=1, tick_o=1.
  - If a handshake and en_i both occur at the same edge, the first period uses the new divisor.
- State RUN, per edge:
  - If cnt == div_o-1: cnt=0 (period boundary). Otherwise cnt=cnt+1.
  - clk_o = (cnt_next < H_active).
  - tick_o = 1 exactly on edges where cnt_next==0.
- Divisor update in RUN:
  - Handshake stores the value in a pending register; cfg_ready_o drops to 0 until it is applied.
  - The pending value is applied at the next period boundary: it becomes div_o and sets H for the new period.
  - A handshake coinciding with a boundary edge applies immediately to the period starting at that edge; cfg_ready_o stays 1.
  - At most one pending value at a time; cfg_ready_o=0 blocks further offers.
- Stop:
  - en_i=0 in RUN does not truncate the current period.
  - At the next boundary edge: go to IDLE, clk_o=0, tick_o=0, running_o=0. Any pending divisor is applied to div_o at that edge.
  - If en_i returns to 1 before that boundary, RUN continues seamlessly with no gap.
- Output timing: clk_o, tick_o, running_o and div_o are all registered; there is no combinational path from inputs to outputs.
- Reset mid-operation: immediate return to reset values. Any pending divisor is discarded.

Decomposition:
- Package clock_divider_pkg:
  - state typedef enum {IDLE, RUN}.
  - function clamp_div(WIDTH-bit) returning the value with 0/1 mapped to 2.
  - function high_time(D) = (D+1)>>1.
- One sub-module, clkdiv_cfg_slot: pending-divisor register plus ready logic (accept, hold, apply at boundary, clear on reset).
- Main module contains the FSM, counter and output registers.

Test Plan:
- Reset, en_i=1, RESET_DIV=2 -> first edge clk_o=1, tick_o=1; clk_o toggles every cycle; tick_o every 2 cycles; div_o=2.
- Load D=5 in IDLE, then enable -> clk_o high 3 cycles / low 2 cycles repeating; tick_o period 5; cfg_ready_o stays 1.
- Running with D=4, load D=6 when cnt=1 -> cfg_ready_o=0 for 2 cycles; current period stays 4 cycles; next period high 3 / low 3; div_o changes 6 at boundary.
- cfg_div_i=0 and cfg_div_i=1 -> div_o=2; behaviour identical to D=2.
- D=255 (WIDTH=8), deassert en_i at cnt=10 -> clk_o completes the period (low until cnt=254); IDLE at boundary; clk_o=0; no runt pulse.
- D=7, assert rst_i at cnt=2 with a pending update -> all outputs reset immediately; div_o=RESET_DIV; pending value lost; cfg_ready_o=1.

Source files
------------

// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_pkg
//  Purpose  : Shared types and divisor helpers for the programmable divider.
//  Revision : 1.0  initial release
// ============================================================================
package clock_divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Divisors 0 and 1 cannot form a clock period with a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    // ceil(d/2); written as a split sum so the all-ones divisor cannot overflow
    function automatic logic [31:0] high_time(input logic [31:0] d);
        return {1'b0, d[31:1]} + {31'b0, d[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_cfg_slot.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_cfg_slot
//  Purpose  : Single-entry pending-divisor slot with valid/ready acceptance.
//  Revision : 1.0  initial release
// ============================================================================
module clkdiv_cfg_slot
    import clock_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_defer,
    input  logic             i_apply,
    output logic             o_ready,
    output logic             o_accept,
    output logic [WIDTH-1:0] o_acc_div,
    output logic             o_pend_vld,
    output logic [WIDTH-1:0] o_pend_div
);

    logic             r_pend_vld;
    logic [WIDTH-1:0] r_pend_div;

    assign o_ready    = ~r_pend_vld;
    assign o_accept   = i_valid & ~r_pend_vld;
    assign o_acc_div  = WIDTH'(clamp_div(32'(i_div)));
    assign o_pend_vld = r_pend_vld;
    assign o_pend_div = r_pend_div;

    // Only offers that cannot be applied at this edge are parked here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_vld <= 1'b0;
            r_pend_div <= '0;
        end else if (i_apply) begin
            r_pend_vld <= 1'b0;
        end else if (o_accept && i_defer) begin
            r_pend_vld <= 1'b1;
            r_pend_div <= o_acc_div;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_prog
//  Purpose  : Run-time programmable glitch-free integer clock divider.
//  Revision : 1.0  initial release
// ============================================================================
module clock_divider_prog
    import clock_divider_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [WIDTH-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic [WIDTH-1:0] div_o,
    output logic             running_o
);

    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_reset_div = WIDTH'(RESET_DIV);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_hi;
    logic             r_clk;
    logic             w_clk_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             w_boundary;
    logic             w_defer;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_div;
    logic             w_pend_vld;
    logic [WIDTH-1:0] w_pend_div;

    assign w_boundary = (r_state == RUN) && (r_cnt == (r_div - c_one));
    assign w_defer    = (r_state == RUN) && !w_boundary;

    clkdiv_cfg_slot #(
        .WIDTH (WIDTH)
    ) u_cfg_slot (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_valid    (cfg_valid_i),
        .i_div      (cfg_div_i),
        .i_defer    (w_defer),
        .i_apply    (w_boundary),
        .o_ready    (w_ready),
        .o_accept   (w_accept),
        .o_acc_div  (w_acc_div),
        .o_pend_vld (w_pend_vld),
        .o_pend_div (w_pend_div)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_clk_nxt   = r_clk;
        w_tick_nxt  = 1'b0;
        w_hi        = WIDTH'(high_time(32'(r_div)));
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_accept) begin
                    w_div_nxt = w_acc_div;
                end
                if (en_i) begin
                    w_state_nxt = RUN;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (w_boundary) begin
                    // Divisor changes and stop requests only land here, so the
                    // new period always opens with a full-width high phase.
                    w_cnt_nxt = '0;
                    if (w_pend_vld) begin
                        w_div_nxt = w_pend_div;
                    end else if (w_accept) begin
                        w_div_nxt = w_acc_div;
                    end
                    if (en_i) begin
                        w_clk_nxt  = 1'b1;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_clk_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                    w_clk_nxt = (w_cnt_nxt < w_hi);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_div  <= c_reset_div;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_div  <= w_div_nxt;
            r_clk  <= w_clk_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign cfg_ready_o = w_ready;
    assign clk_o       = r_clk;
    assign tick_o      = r_tick;
    assign div_o       = r_div;
    assign running_o   = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider_prog
//  Purpose  : Directed bench with a period-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_divider_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       dclk;
    logic       tick;
    logic [7:0] div;
    logic       running;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_divider_prog #(
        .WIDTH     (8),
        .RESET_DIV (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .cfg_valid_i (cfg_valid),
        .cfg_div_i   (cfg_div),
        .cfg_ready_o (cfg_ready),
        .clk_o       (dclk),
        .tick_o      (tick),
        .div_o       (div),
        .running_o   (running)
    );

    always #5 clk = ~clk;

    // Reference: each started period is expanded into its full list of
    // {clk,tick} samples; an empty list means the current edge is a boundary.
    logic [1:0] m_q[$];
    logic       m_run;
    logic [7:0] m_div;
    logic       m_pvld;
    logic [7:0] m_pdiv;
    logic       m_clk;
    logic       m_tick;

    function automatic logic [7:0] mclamp(input logic [7:0] d);
        return (d < 8'd2) ? 8'd2 : d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run  = 1'b0;
        m_div  = 8'd2;
        m_pvld = 1'b0;
        m_pdiv = 8'd0;
        m_clk  = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_pop();
        logic [1:0] e;
        e      = m_q.pop_front();
        m_clk  = e[1];
        m_tick = e[0];
    endtask

    task automatic model_start(input logic [7:0] d);
        for (int i = 0; i < int'(d); i++) begin
            m_q.push_back({(i < (int'(d) + 1) / 2), (i == 0)});
        end
        model_pop();
    endtask

    task automatic model_step();
        logic acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = cfg_valid && !m_pvld;
        if (!m_run) begin
            if (acc) m_div = mclamp(cfg_div);
            if (en) begin
                m_run = 1'b1;
                model_start(m_div);
            end else begin
                m_clk  = 1'b0;
                m_tick = 1'b0;
            end
        end else if (m_q.size() == 0) begin
            if (m_pvld) begin
                m_div  = m_pdiv;
                m_pvld = 1'b0;
            end else if (acc) begin
                m_div = mclamp(cfg_div);
            end
            if (en) begin
                model_start(m_div);
            end else begin
                m_run  = 1'b0;
                m_clk  = 1'b0;
                m_tick = 1'b0;
            end
        end else begin
            if (acc) begin
                m_pvld = 1'b1;
                m_pdiv = mclamp(cfg_div);
            end
            model_pop();
        end
    endtask

    task automatic model_compare();
        logic [11:0] act;
        logic [11:0] exp;
        act = {dclk, tick, running, cfg_ready, div};
        exp = {m_clk, m_tick, m_run, !m_pvld, m_div};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle @%0t: dut clk/tick/run/rdy/div=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                     $time, dclk, tick, running, cfg_ready, div,
                     m_clk, m_tick, m_run, !m_pvld, m_div);
        end
    endtask

    // One clk_i cycle: model follows the rising edge, outputs checked mid-cycle.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (!rst) model_compare();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!running) return;
            cyc();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_idle: running_o still 1 required 0");
    endtask

    task automatic load_idle(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] p5_clk;
        logic [9:0] p5_tick;
        logic [5:0] p6_clk;
        logic [7:0] offers[4];
        int         n_run;
        int         n_hi;
        bit         done;

        p5_clk    = 10'b1110011100;
        p5_tick   = 10'b1000010000;
        p6_clk    = 6'b111000;
        offers[0] = 8'd9;
        offers[1] = 8'd3;
        offers[2] = 8'd1;
        offers[3] = 8'd4;

        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("reset clk_o", 32'(dclk), 0);
        chk("reset tick_o", 32'(tick), 0);
        chk("reset running_o", 32'(running), 0);
        chk("reset div_o", 32'(div), 2);
        chk("reset cfg_ready_o", 32'(cfg_ready), 1);

        // Divide by 2 straight out of reset
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("d2 clk_o", 32'(dclk), 32'((i % 2) == 0));
            chk("d2 tick_o", 32'(tick), 32'((i % 2) == 0));
        end
        chk("d2 div_o", 32'(div), 2);

        // Divide by 5 loaded in IDLE
        en = 1'b0;
        wait_idle();
        load_idle(8'd5);
        chk("d5 div_o", 32'(div), 5);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("d5 clk_o", 32'(dclk), 32'(p5_clk[9-i]));
            chk("d5 tick_o", 32'(tick), 32'(p5_tick[9-i]));
        end
        chk("d5 cfg_ready_o", 32'(cfg_ready), 1);

        // 4 -> 6 while running, offered at cnt=1
        en = 1'b0;
        wait_idle();
        load_idle(8'd4);
        en = 1'b1;
        cyc();
        cyc();
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        cyc();
        cfg_valid = 1'b0;
        chk("upd ready cnt2", 32'(cfg_ready), 0);
        chk("upd clk cnt2", 32'(dclk), 0);
        chk("upd div old", 32'(div), 4);
        cyc();
        chk("upd ready cnt3", 32'(cfg_ready), 0);
        cyc();
        chk("upd div new", 32'(div), 6);
        chk("upd tick", 32'(tick), 1);
        chk("upd ready back", 32'(cfg_ready), 1);
        chk("upd clk cnt0", 32'(dclk), 1);
        for (int i = 1; i < 6; i++) begin
            cyc();
            chk("d6 clk_o", 32'(dclk), 32'(p6_clk[5-i]));
        end

        // en_i dips mid-period and returns before the boundary
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        cyc();
        en = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("seamless running", 32'(running), 1);
        chk("seamless tick", 32'(tick), 1);

        // Clamp of 0 and 1
        en = 1'b0;
        wait_idle();
        load_idle(8'd0);
        chk("clamp 0", 32'(div), 2);
        load_idle(8'd7);
        load_idle(8'd1);
        chk("clamp 1", 32'(div), 2);
        en = 1'b1;
        repeat (4) cyc();
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        cyc();
        cfg_valid = 1'b0;
        repeat (4) cyc();
        chk("clamp run", 32'(div), 2);

        // D=255, stop requested at cnt=10 must finish the whole period
        en = 1'b0;
        wait_idle();
        load_idle(8'd255);
        en    = 1'b1;
        n_run = 0;
        n_hi  = 0;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc();
            if (!running) begin
                done = 1'b1;
            end else begin
                n_run++;
                if (dclk) n_hi++;
                if (n_run == 11) en = 1'b0;
            end
        end
        chk("stop completed", 32'(done), 1);
        chk("stop period length", 32'(n_run), 255);
        chk("stop high cycles", 32'(n_hi), 128);
        chk("stop clk_o", 32'(dclk), 0);
        chk("stop tick_o", 32'(tick), 0);

        // Reset at cnt=2 with a pending update discards it
        load_idle(8'd7);
        en = 1'b1;
        cyc();
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        chk("pend ready", 32'(cfg_ready), 0);
        cyc();
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("rst clk_o", 32'(dclk), 0);
        chk("rst tick_o", 32'(tick), 0);
        chk("rst running_o", 32'(running), 0);
        chk("rst div_o", 32'(div), 2);
        chk("rst cfg_ready_o", 32'(cfg_ready), 1);
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("post rst div_o", 32'(div), 2);
        chk("post rst ready", 32'(cfg_ready), 1);

        // Offers at assorted points of running D=2 periods
        foreach (offers[k]) begin
            cfg_valid = 1'b1;
            cfg_div   = offers[k];
            cyc();
            cfg_valid = 1'b0;
            repeat (12) cyc();
        end
        en = 1'b0;
        wait_idle();
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
